reg_file_mp: RTL

- Parametrised multi-port integer register file for the pipelined RISC-V core; next generation of the single-cycle register file.
- Adds: configurable width, depth and read-port count; two write ports with a fixed priority; optional write-to-read bypass; a per-register busy scoreboard for hazard detection.
- Sits between decode (read and issue side) and writeback (two write ports: ALU result and load result).

---
 rtl/reg_file_mp.sv | 69 ++++++
 1 files changed

// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-port integer register file with two prioritised write ports,
// optional write-to-read bypass and a per-register busy scoreboard.
module reg_file_mp #(
    parameter int XLEN     = 32,
    parameter int DEPTH    = 32,
    parameter int NRD      = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   raddr,
    output logic [NRD*XLEN-1:0] rdata,
    output logic [NRD-1:0]      rbusy,
    input  logic                we0,
    input  logic [AW-1:0]       waddr0,
    input  logic [XLEN-1:0]     wdata0,
    input  logic                we1,
    input  logic [AW-1:0]       waddr1,
    input  logic [XLEN-1:0]     wdata1,
    input  logic                iss_valid,
    input  logic [AW-1:0]       iss_rd,
    output logic [DEPTH-1:0]    busy_vec
);
    localparam bit BYP = BYPASS != 0;
    localparam bit ZR  = ZERO_REG != 0;
    logic [XLEN-1:0]  mem [DEPTH];
    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] busy_nxt;
    logic             wr0;
    logic             wr1;
    logic             set_ok;
    assign wr0      = we0 && !(ZR && waddr0 == '0);
    assign wr1      = we1 && !(ZR && waddr1 == '0);
    assign set_ok   = iss_valid && !(ZR && iss_rd == '0);
    assign busy_vec = busy;
    // Set is applied after clear so a fresh producer keeps ownership.
    always_comb begin
        busy_nxt = busy;
        if (we0) busy_nxt[waddr0] = 1'b0;
        if (we1) busy_nxt[waddr1] = 1'b0;
        if (set_ok) busy_nxt[iss_rd] = 1'b1;
    end
    // Port 1 is written last so it wins a same-address collision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            busy <= '0;
        end else begin
            if (wr0) mem[waddr0] <= wdata0;
            if (wr1) mem[waddr1] <= wdata1;
            busy <= busy_nxt;
        end
    end
    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0] a;
        logic          zr;
        logic          hit0;
        logic          hit1;
        assign a    = raddr[k*AW +: AW];
        assign zr   = ZR && a == '0;
        assign hit1 = BYP && we1 && waddr1 == a;
        assign hit0 = BYP && we0 && waddr0 == a;
        // Gating on rst keeps bypassed write data off the outputs during reset.
        assign rdata[k*XLEN +: XLEN] = (rst || zr) ? '0 : hit1 ? wdata1 : hit0 ? wdata0 : mem[a];
        assign rbusy[k] = !(rst || zr || hit0 || hit1) && busy[a];
    end
endmodule
